// File: rtl/seven_seg_reader.sv
// Snoops a multiplexed 7-segment bus and recovers the BCD value shown at each digit.
// Define SEVEN_SEG_READER_ACTIVE_LOW_EN for common-anode boards (seg/an inverted on entry).
module seven_seg_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic                    err_clr,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    upd,
    output logic [2:0]              upd_idx,
    output logic                    frame_done,
    output logic                    err
);

    localparam int         W      = NUM_DIGITS + 7;
    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [W-1:0]            in_word;
    logic [W-1:0]            sample_reg;
    logic [W-1:0]            prev_reg;
    logic [NUM_DIGITS-1:0]   an_s;
    logic [6:0]              seg_s;
    logic                    one_hot;
    logic [7:0]              cnt_reg;
    logic [7:0]              cnt_next;
    logic                    captured_reg;
    logic                    captured_next;
    logic                    capture;
    logic [3:0]              dec_val;
    logic                    dec_valid;
    logic                    dec_bad;
    logic [2:0]              idx_next;
    logic [NUM_DIGITS-1:0]   seen_reg;
    logic [NUM_DIGITS-1:0]   seen_or;
    logic                    frame_full;
    logic                    upd_reg;
    logic [2:0]              upd_idx_reg;
    logic                    frame_done_reg;
    logic                    err_reg;
    logic [3:0]              digit_reg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   valid_reg;

`ifdef SEVEN_SEG_READER_ACTIVE_LOW_EN
    assign in_word = ~{an, seg};
`else
    assign in_word = {an, seg};
`endif

    assign an_s    = sample_reg[W-1:7];
    assign seg_s   = sample_reg[6:0];
    assign one_hot = (an_s != '0) && ((an_s & (an_s - NUM_DIGITS'(1))) == '0);

    // Counter tracks how long the registered pattern has matched its predecessor.
    always_comb begin
        cnt_next = cnt_reg;
        if ((sample_reg != prev_reg) || !one_hot) begin
            cnt_next = '0;
        end else if (cnt_reg != STABLE) begin
            cnt_next = cnt_reg + 8'd1;
        end
    end

    // The captured flag re-arms only when the pattern breaks, so a long hold captures once.
    assign capture       = (cnt_next == STABLE) && !captured_reg;
    assign captured_next = (cnt_next == '0) ? 1'b0 : (captured_reg | capture);

    always_comb begin
        dec_val   = 4'hE;
        dec_valid = 1'b0;
        dec_bad   = 1'b1;
        case (seg_s)
            7'b1111110: begin dec_val = 4'd0; dec_valid = 1'b1; dec_bad = 1'b0; end
            7'b0110000: begin dec_val = 4'd1; dec_valid = 1'b1; dec_bad = 1'b0; end
            7'b1101101: begin dec_val = 4'd2; dec_valid = 1'b1; dec_bad = 1'b0; end
            7'b1111001: begin dec_val = 4'd3; dec_valid = 1'b1; dec_bad = 1'b0; end
            7'b0110011: begin dec_val = 4'd4; dec_valid = 1'b1; dec_bad = 1'b0; end
            7'b1011011: begin dec_val = 4'd5; dec_valid = 1'b1; dec_bad = 1'b0; end
            7'b1011111: begin dec_val = 4'd6; dec_valid = 1'b1; dec_bad = 1'b0; end
            7'b1110000: begin dec_val = 4'd7; dec_valid = 1'b1; dec_bad = 1'b0; end
            7'b1111111: begin dec_val = 4'd8; dec_valid = 1'b1; dec_bad = 1'b0; end
            7'b1111011: begin dec_val = 4'd9; dec_valid = 1'b1; dec_bad = 1'b0; end
            7'b0000000: begin dec_val = 4'hF; dec_valid = 1'b0; dec_bad = 1'b0; end
            default:    begin dec_val = 4'hE; dec_valid = 1'b0; dec_bad = 1'b1; end
        endcase
    end

    always_comb begin
        idx_next = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_s[i]) begin
                idx_next = 3'(i);
            end
        end
    end

    assign seen_or    = seen_reg | an_s;
    assign frame_full = &seen_or;

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_reg     <= '0;
            prev_reg       <= '0;
            cnt_reg        <= '0;
            captured_reg   <= 1'b0;
            seen_reg       <= '0;
            upd_reg        <= 1'b0;
            upd_idx_reg    <= '0;
            frame_done_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            sample_reg     <= in_word;
            prev_reg       <= sample_reg;
            cnt_reg        <= cnt_next;
            captured_reg   <= captured_next;
            upd_reg        <= capture;
            frame_done_reg <= capture && frame_full;
            if (capture) begin
                upd_idx_reg <= idx_next;
                seen_reg    <= frame_full ? '0 : seen_or;
            end
            if (capture && dec_bad) begin
                err_reg <= 1'b1;
            end else if (err_clr) begin
                err_reg <= 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            always_ff @(posedge clk) begin
                if (rst) begin
                    digit_reg[gi] <= 4'hF;
                    valid_reg[gi] <= 1'b0;
                end else if (capture && an_s[gi]) begin
                    digit_reg[gi] <= dec_val;
                    valid_reg[gi] <= dec_valid;
                end
            end
            assign digits[4*gi +: 4] = digit_reg[gi];
        end
    endgenerate

    assign digit_valid = valid_reg;
    assign upd         = upd_reg;
    assign upd_idx     = upd_idx_reg;
    assign frame_done  = frame_done_reg;
    assign err         = err_reg;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Bench for seven_seg_reader: run-length reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_seven_seg_reader;

    localparam int N = 4;
    localparam int S = 4;
    localparam logic [6:0] SEG_TAB [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    logic           clk = 1'b0;
    logic           rst;
    logic [6:0]     seg;
    logic [N-1:0]   an;
    logic           err_clr;
    logic [4*N-1:0] digits;
    logic [N-1:0]   digit_valid;
    logic           upd;
    logic [2:0]     upd_idx;
    logic           frame_done;
    logic           err;

    always #5 clk = ~clk;

    seven_seg_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .seg(seg), .an(an), .err_clr(err_clr),
        .digits(digits), .digit_valid(digit_valid), .upd(upd), .upd_idx(upd_idx),
        .frame_done(frame_done), .err(err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int upd_cnt = 0;
    int fd_cnt = 0;
    int fd_idx = -1;
    int fd_with_upd = 0;
    int first_upd_cyc = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int decode(input logic [6:0] s);
        for (int d = 0; d < 10; d++) begin
            if (s == SEG_TAB[d]) return d;
        end
        if (s == 7'b0000000) return 15;
        return 14;
    endfunction

    // Reference model: a digit is captured once a one-hot pattern has been
    // sampled on S+1 consecutive edges, the capture appearing on the next edge.
    logic [N+6:0]   run_pat;
    int             run_len = 0;
    logic [4*N-1:0] exp_digits;
    logic [N-1:0]   exp_valid;
    logic           exp_upd;
    logic [2:0]     exp_idx;
    logic           exp_fd;
    logic           exp_err;
    logic [N-1:0]   seen_m;
    bit             started = 0;

    always @(posedge clk) begin : model
        logic [N+6:0] cur;
        logic [N-1:0] a;
        int           v;
        int           idx;
        cyc++;
        cur = {an, seg};
`ifdef SEVEN_SEG_READER_ACTIVE_LOW_EN
        cur = ~cur;
`endif
        if (rst) begin
            exp_digits = '1;
            exp_valid  = '0;
            exp_upd    = 1'b0;
            exp_idx    = '0;
            exp_fd     = 1'b0;
            exp_err    = 1'b0;
            seen_m     = '0;
            run_len    = 0;
            started    = 1;
        end else begin
            exp_upd = 1'b0;
            exp_fd  = 1'b0;
            if (run_len == S + 1 && $onehot(run_pat[N+6:7])) begin
                a   = run_pat[N+6:7];
                idx = 0;
                for (int i = 0; i < N; i++) if (a[i]) idx = i;
                v = decode(run_pat[6:0]);
                exp_digits[4*idx +: 4] = 4'(v);
                exp_valid[idx]         = (v < 10);
                if (v == 14) exp_err = 1'b1;
                else if (err_clr) exp_err = 1'b0;
                exp_upd = 1'b1;
                exp_idx = 3'(idx);
                if ((seen_m | a) == {N{1'b1}}) begin
                    exp_fd = 1'b1;
                    seen_m = '0;
                end else begin
                    seen_m = seen_m | a;
                end
            end else if (err_clr) begin
                exp_err = 1'b0;
            end
            if (run_len > 0 && cur == run_pat) begin
                if (run_len < 1000) run_len++;
            end else begin
                run_pat = cur;
                run_len = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("digits", 32'(digits), 32'(exp_digits));
            chk("digit_valid", 32'(digit_valid), 32'(exp_valid));
            chk("upd", 32'(upd), 32'(exp_upd));
            chk("upd_idx", 32'(upd_idx), 32'(exp_idx));
            chk("frame_done", 32'(frame_done), 32'(exp_fd));
            chk("err", 32'(err), 32'(exp_err));
            if (upd === 1'b1) begin
                upd_cnt++;
                if (first_upd_cyc < 0) first_upd_cyc = cyc;
                $display("cyc %0d upd idx=%0d digits=%h valid=%b frame_done=%b err=%b",
                         cyc, upd_idx, digits, digit_valid, frame_done, err);
            end
            if (frame_done === 1'b1) begin
                fd_cnt++;
                fd_idx      = int'(upd_idx);
                fd_with_upd = int'(upd);
            end
        end
    end

    task automatic hold(input logic [N-1:0] a, input logic [6:0] s, input int n);
`ifdef SEVEN_SEG_READER_ACTIVE_LOW_EN
        an  = ~a;
        seg = ~s;
`else
        an  = a;
        seg = s;
`endif
        repeat (n) @(negedge clk);
    endtask

    int k;
    int base;

    initial begin
        rst = 1'b1;
        err_clr = 1'b0;
        hold('0, 7'b0000000, 1);
        #1;
        chk("reset_digits", 32'(digits), 32'h0000_FFFF);
        chk("reset_valid", 32'(digit_valid), 32'h0);
        chk("reset_upd", 32'(upd), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Single digit 5 on position 0
        #2;
        first_upd_cyc = -1;
        upd_cnt = 0;
        k = cyc + 1;
        hold(4'b0001, 7'b1011011, 10);
        #2;
        chk("t1_upd_count", 32'(upd_cnt), 32'd1);
        chk("t1_latency", 32'(first_upd_cyc), 32'(k + S + 1));
        chk("t1_digit0", 32'(digits[3:0]), 32'd5);
        chk("t1_valid0", 32'(digit_valid[0]), 32'd1);

        // Scan 1,2,3,9 across all positions
        fd_cnt = 0;
        hold(4'b0001, 7'b0110000, 6);
        hold(4'b0010, 7'b1101101, 6);
        hold(4'b0100, 7'b1111001, 6);
        hold(4'b1000, 7'b1111011, 6);
        #2;
        chk("t2_digits", 32'(digits), 32'h9321);
        chk("t2_valid", 32'(digit_valid), 32'hF);
        chk("t2_upd_count", 32'(upd_cnt), 32'd5);
        chk("t2_fd_count", 32'(fd_cnt), 32'd1);
        chk("t2_fd_idx", 32'(fd_idx), 32'd3);
        chk("t2_fd_with_upd", 32'(fd_with_upd), 32'd1);

        // Glitches: short holds and a multi-hot select never capture
        hold(4'b0001, 7'b1111111, 4);
        hold(4'b0001, 7'b1110000, 4);
        hold(4'b0011, 7'b1011011, 10);
        hold(4'b0000, 7'b0000000, 2);
        #2;
        chk("t3_no_upd", 32'(upd_cnt), 32'd5);
        chk("t3_digits", 32'(digits), 32'h9321);
        hold(4'b0001, 7'b0110011, 6);
        #2;
        chk("t3_recover", 32'(digits[3:0]), 32'd4);
        chk("t3_upd_count", 32'(upd_cnt), 32'd6);

        // Undecodable pattern, clear, then clear colliding with a new error
        hold(4'b0100, 7'b1000001, 6);
        #2;
        chk("t4_digit2", 32'(digits[11:8]), 32'hE);
        chk("t4_valid2", 32'(digit_valid[2]), 32'd0);
        chk("t4_err_set", 32'(err), 32'd1);
        err_clr = 1'b1;
        hold(4'b0000, 7'b0000000, 1);
        err_clr = 1'b0;
        hold(4'b0000, 7'b0000000, 1);
        #2;
        chk("t4_err_cleared", 32'(err), 32'd0);
        base = upd_cnt;
        hold(4'b0100, 7'b1000001, 5);
        err_clr = 1'b1;
        hold(4'b0100, 7'b1000001, 1);
        err_clr = 1'b0;
        #2;
        chk("t4_set_wins", 32'(err), 32'd1);
        chk("t4_upd", 32'(upd_cnt), 32'(base + 1));

        // Blank pattern on digit 1
        err_clr = 1'b1;
        hold(4'b0000, 7'b0000000, 1);
        err_clr = 1'b0;
        hold(4'b0010, 7'b0000000, 6);
        #2;
        chk("t5_digit1", 32'(digits[7:4]), 32'hF);
        chk("t5_valid1", 32'(digit_valid[1]), 32'd0);
        chk("t5_err", 32'(err), 32'd0);

        // Reset in the middle of a hold restarts the stability window
        hold(4'b1000, 7'b1011111, 2);
        rst = 1'b1;
        hold(4'b1000, 7'b1011111, 1);
        rst = 1'b0;
        base = upd_cnt;
        hold(4'b1000, 7'b1011111, 4);
        #2;
        chk("t6_no_early_upd", 32'(upd_cnt), 32'(base));
        hold(4'b1000, 7'b1011111, 2);
        #2;
        chk("t6_upd", 32'(upd_cnt), 32'(base + 1));
        chk("t6_digits", 32'(digits), 32'h6FFF);

`ifdef SEVEN_SEG_READER_ACTIVE_LOW_EN
        // Raw lines an=1110, seg=0000000 on a common-anode board read as 8
        hold(4'b0001, 7'b1111111, 6);
        #2;
        chk("t7_raw_an", 32'(an), 32'hE);
        chk("t7_digit0_8", 32'(digits[3:0]), 32'd8);
`endif

        hold(4'b0000, 7'b0000000, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_reader.md
Name: seven_seg_reader

Overview:
- Reads a multiplexed 7-segment display bus and reconstructs the BCD digit value shown at each digit position.
- Inverse of the team's BCD-to-7-segment decoder. Sits on the display side as a snoop/checker: the bench and on-chip self-test compare the recovered digits against the intended values.
- Filters scan glitches by requiring a stable segment/anode pattern before capture.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (anode lines), 1..8
- STABLE_CYCLES, 4, consecutive sampled cycles a pattern must hold before capture, 2..255

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- seg  input  7  segment lines, bit6=a … bit0=g, active-high
- an  input  NUM_DIGITS  digit select, one-hot, active-high; bit i selects digit i
- err_clr  input  1  clears err
- digits  output  4*NUM_DIGITS  recovered values; digit i at [4i+3:4i]
- digit_valid  output  NUM_DIGITS  bit i=1 when digit i last decoded as 0..9
- upd  output  1  one-cycle pulse on each capture
- upd_idx  output  3  index of the digit captured with upd
- frame_done  output  1  one-cycle pulse when every digit has been captured at least once since the last frame_done or reset
- err  output  1  sticky: an undecodable pattern was captured

Behaviour:
- Reset values (rst high at an edge): digits=all 4'hF, digit_valid=0, upd=0, upd_idx=0, frame_done=0, err=0. Sample registers, stability counter, captured flag and seen mask are all cleared.
- Input stage: {an,seg} is registered every cycle. The stability counter compares the current sample with the previous sample.
- Stability counter:
  - Resets to 0 if the sample differs from the previous sample, or if an is not exactly one-hot (zero or multi-hot).
  - Otherwise increments, saturating at STABLE_CYCLES.
- Capture:
  - Occurs in the cycle the counter reaches STABLE_CYCLES, provided the captured flag is clear.
  - Sets the captured flag. The flag clears only when the counter resets, so a held pattern yields exactly one capture.
- Latency: a pattern presented unchanged from edge k produces upd high after edge k+STABLE_CYCLES+1.
- Decode, applied on capture to digit i = index of the set an bit:
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9. Result: digits[i]=value, digit_valid[i]=1.
  - 0000000 (blank): digits[i]=4'hF, digit_valid[i]=0, err unchanged.
  - Any other pattern: digits[i]=4'hE, digit_valid[i]=0, err←1.
- Capture outputs: upd=1 and upd_idx=i for one cycle. Other digits hold their values.
- Seen mask: bit i is set on each capture of digit i.
  - When a capture makes the mask all ones, frame_done pulses in the same cycle as upd and the mask clears to 0. That capture is not re-counted.
  - Recapturing a digit already in the mask does not pulse frame_done.
- err_clr: clears err on the next edge. If err_clr and a new error capture occur in the same cycle, err=1 (set wins).
- rst mid-hold: all state clears. A pattern still present after reset needs a full STABLE_CYCLES hold to capture again.
- an bits at or above NUM_DIGITS do not exist. upd_idx upper bits are 0 when NUM_DIGITS<8.

Optional Feature:
- SEVEN_SEG_READER_ACTIVE_LOW_EN:
  - Defined: seg and an are inverted at the input stage before any logic, for common-anode boards. All decode values and the one-hot rule then apply to the inverted lines. Latency is unchanged.
  - Undefined: lines are used as active-high, exactly as above.

Test Plan:
- Reset, then an=0001 and seg=1011011 held for 10 cycles → exactly one upd with upd_idx=0, digits[3:0]=5, digit_valid[0]=1, issued STABLE_CYCLES+1=5 edges after the first presentation.
- Scan 4 digits with values 1,2,3,9, each held 6 cycles in order → four upd pulses with idx 0..3, digits=16'h9321, digit_valid=4'hF, and frame_done coincident with the fourth upd only.
- Glitch: pattern changes after 3 stable cycles, or an=0011 held 10 cycles → no upd, counter restarts, no state change.
- seg=1000001 on digit 2 → digits[11:8]=4'hE, err=1. Assert err_clr alone → err=0. Repeat with err_clr asserted in the capture cycle → err stays 1.
- seg=0000000 on digit 1 → digits[7:4]=4'hF, digit_valid[1]=0, err=0.
- With SEVEN_SEG_READER_ACTIVE_LOW_EN defined: an=1110 and seg=0000000 held 6 cycles → digit 0 decodes as 8. Also assert rst 2 cycles into a hold → no upd until a fresh 4-cycle hold completes after reset.
